// File: rtl/led_pkg.sv
// Shared definitions for the LED activity fader: default sizing, level type
// and the full-brightness level helper.
package led_pkg;

   localparam int unsigned LED_NUM_LEDS  = 8;
   localparam int unsigned LED_PWM_BITS  = 3;
   localparam int unsigned LED_DECAY_DIV = 4;
   localparam int unsigned LED_DIM_LEVEL = 1;

   // Brightness level at default PWM width; one bit wider than the PWM counter
   // so that FULL (always-on) is representable.
   typedef logic [LED_PWM_BITS:0] level_t;

   // Level at which the PWM compare is true for every counter value.
   function automatic int unsigned full_level(input int unsigned pwm_bits);
      return 32'd1 << pwm_bits;
   endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One activity channel: input synchroniser, decaying brightness level and
// registered PWM compare.
module led_fader_channel
   import led_pkg::*;
#(
   parameter int unsigned PWM_BITS  = LED_PWM_BITS,
   parameter int unsigned DIM_LEVEL = LED_DIM_LEVEL
) (
   input  logic                clock,
   input  logic                res_n,
   input  logic                led_in,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                tick,
   input  logic                dim_en,
   output logic                led_out,
   output logic                active_c
);

   localparam int unsigned   LW   = PWM_BITS + 1;
   localparam logic [LW-1:0] FULL = LW'(full_level(PWM_BITS));
   localparam logic [LW-1:0] DIM  = LW'(DIM_LEVEL);

   logic          s1;
   logic          s2;
   logic [LW-1:0] level;
   logic [LW-1:0] level_next;

   // led_in comes from the cog clock domain; only s2 is used downstream
   always_ff @(posedge clock or negedge res_n) begin
      if (!res_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= led_in;
         s2 <= s1;
      end
   end

   // Activity reloads the level and takes priority over a decay tick
   always_comb begin
      level_next = level;
      if (s2) begin
         level_next = dim_en ? DIM : FULL;
      end else if (tick && (level != '0)) begin
         level_next = level - LW'(1);
      end
   end

   always_ff @(posedge clock or negedge res_n) begin
      if (!res_n) begin
         level   <= '0;
         led_out <= 1'b0;
      end else begin
         level   <= level_next;
         led_out <= ({1'b0, pwm_cnt} < level);
      end
   end

   assign active_c = (level != '0);

endmodule

// File: rtl/led_activity_fader.sv
// Turns flickering per-cog activity bits into decaying-brightness PWM LED
// drive, with a shared PWM counter, decay prescaler and any-active flag.
module led_activity_fader
   import led_pkg::*;
#(
   parameter int unsigned NUM_LEDS  = LED_NUM_LEDS,
   parameter int unsigned PWM_BITS  = LED_PWM_BITS,
   parameter int unsigned DECAY_DIV = LED_DECAY_DIV,
   parameter int unsigned DIM_LEVEL = LED_DIM_LEVEL
) (
   input  logic                clock,
   input  logic                res_n,
   input  logic [NUM_LEDS-1:0] led_in,
   input  logic                dim_en,
   output logic [NUM_LEDS-1:0] led_out,
   output logic                any_active
);

   localparam int unsigned DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [DW-1:0]       pre_cnt;
   logic                tick_c;
   logic [NUM_LEDS-1:0] active_c;

   // Free-running PWM phase shared by all channels; wraps naturally
   always_ff @(posedge clock or negedge res_n) begin
      if (!res_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end

   // Decay prescaler: tick marks the last count of each DECAY_DIV window
   assign tick_c = (pre_cnt == DW'(DECAY_DIV - 1));

   always_ff @(posedge clock or negedge res_n) begin
      if (!res_n) begin
         pre_cnt <= '0;
      end else if (tick_c) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + DW'(1);
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_fader_channel #(
         .PWM_BITS  (PWM_BITS),
         .DIM_LEVEL (DIM_LEVEL)
      ) u_ch (
         .clock    (clock),
         .res_n    (res_n),
         .led_in   (led_in[i]),
         .pwm_cnt  (pwm_cnt),
         .tick     (tick_c),
         .dim_en   (dim_en),
         .led_out  (led_out[i]),
         .active_c (active_c[i])
      );
   end

   always_ff @(posedge clock or negedge res_n) begin
      if (!res_n) begin
         any_active <= 1'b0;
      end else begin
         any_active <= |active_c;
      end
   end

endmodule

// File: tb/tb_led_activity_fader.sv
// Directed and randomized bench for led_activity_fader against a cycle-level
// behavioural model of the fader rules.
module tb_led_activity_fader;
   import led_pkg::*;

   localparam int NUM  = 8;
   localparam int PB   = 3;
   localparam int DIV  = 4;
   localparam int DIM  = 1;
   localparam int FULL = 8;
   localparam int PER  = 1 << PB;

   logic           clock;
   logic           res_n;
   logic [NUM-1:0] led_in;
   logic           dim_en;
   logic [NUM-1:0] led_out;
   logic           any_active;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic m_s1 [NUM];
   logic m_s2 [NUM];
   int   m_lvl [NUM];
   int   m_pwm;
   int   m_pre;
   logic [NUM-1:0] m_out;
   logic           m_any;

   led_activity_fader #(
      .NUM_LEDS  (NUM),
      .PWM_BITS  (PB),
      .DECAY_DIV (DIV),
      .DIM_LEVEL (DIM)
   ) dut (
      .clock      (clock),
      .res_n      (res_n),
      .led_in     (led_in),
      .dim_en     (dim_en),
      .led_out    (led_out),
      .any_active (any_active)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM; i++) begin
         m_s1[i]  = 1'b0;
         m_s2[i]  = 1'b0;
         m_lvl[i] = 0;
      end
      m_pwm = 0;
      m_pre = 0;
      m_out = '0;
      m_any = 1'b0;
   endtask

   // One clock edge of the fader rules, from the values before the edge
   task automatic model_edge();
      bit tick;
      logic [NUM-1:0] nout;
      logic nany;
      tick = (m_pre == DIV - 1);
      nout = '0;
      nany = 1'b0;
      for (int i = 0; i < NUM; i++) begin
         nout[i] = (m_pwm < m_lvl[i]);
         if (m_lvl[i] != 0) nany = 1'b1;
      end
      for (int i = 0; i < NUM; i++) begin
         if (m_s2[i])                     m_lvl[i] = dim_en ? DIM : FULL;
         else if (tick && m_lvl[i] > 0)   m_lvl[i] = m_lvl[i] - 1;
         m_s2[i] = m_s1[i];
         m_s1[i] = led_in[i];
      end
      m_pwm = (m_pwm + 1) % PER;
      m_pre = (m_pre + 1) % DIV;
      m_out = nout;
      m_any = nany;
   endtask

   // Drive inputs after a falling edge, advance one cycle, compare after the rising edge
   task automatic cyc(input logic [NUM-1:0] li, input logic de);
      led_in = li;
      dim_en = de;
      @(posedge clock);
      if (res_n) model_edge();
      #1;
      check("led_out", 32'(led_out), 32'(m_out));
      check("any_active", 32'(any_active), 32'(m_any));
      @(negedge clock);
   endtask

   task automatic do_reset();
      res_n = 1'b0;
      #1;
      model_clear();
      check("rst_led_out", 32'(led_out), 32'd0);
      check("rst_any_active", 32'(any_active), 32'd0);
   endtask

   initial begin
      logic [NUM-1:0] li;
      logic de;

      res_n  = 1'b0;
      led_in = '1;
      dim_en = 1'b0;
      model_clear();
      @(negedge clock);

      // Held in reset with all inputs active
      repeat (6) cyc(8'hFF, 1'b0);
      res_n = 1'b1;
      repeat (200) cyc(8'h00, 1'b0);

      // Latency of a held input on channel 0
      cyc(8'h01, 1'b0);
      cyc(8'h01, 1'b0);
      cyc(8'h01, 1'b0);
      check("lat_edge3", 32'(led_out), 32'd0);
      cyc(8'h01, 1'b0);
      check("lat_edge4", 32'(led_out), 32'h01);
      check("lat_any4", 32'(any_active), 32'd1);
      repeat (30) cyc(8'h01, 1'b0);
      check("hold0_on", 32'(led_out), 32'h01);
      repeat (45) cyc(8'h00, 1'b0);

      // Single-clock pulse on channel 2 fades fully
      cyc(8'h04, 1'b0);
      repeat (45) cyc(8'h00, 1'b0);
      check("fade_done_out", 32'(led_out), 32'd0);
      check("fade_done_any", 32'(any_active), 32'd0);

      // Dim level on channel 5
      repeat (40) cyc(8'h20, 1'b1);
      repeat (10) cyc(8'h00, 1'b1);

      // Load beats decay on channel 3
      repeat (60) cyc(8'h08, 1'b0);
      check("hold3_on", 32'(led_out), 32'h08);
      repeat (45) cyc(8'h00, 1'b0);

      // Reset in the middle of a fade at level 5
      cyc(8'h04, 1'b0);
      for (int k = 0; k < 40 && m_lvl[2] != 5; k++) cyc(8'h00, 1'b0);
      check("midfade_level5", 32'(m_lvl[2]), 32'd5);
      do_reset();
      repeat (3) cyc(8'h00, 1'b0);
      res_n = 1'b1;
      repeat (20) cyc(8'h00, 1'b0);

      // Random sparse activity with dim toggles and occasional resets
      de = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
            repeat ($urandom_range(1, 3)) cyc(NUM'($urandom), de);
            res_n = 1'b1;
         end
         li = '0;
         for (int b = 0; b < NUM; b++) begin
            if ($urandom_range(0, 15) == 0) li[b] = 1'b1;
         end
         if ($urandom_range(0, 63) == 0) de = ~de;
         cyc(li, de);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_activity_fader.md
Name: led_activity_fader

Overview:
- Sits between the core's per-cog activity LED vector and the board LED pins.
- Turns short or flickering cog activity bits into visible, decaying-brightness PWM drive, so brief cog activity stays visible instead of collapsing into a fixed-duty "dim" gate.
- Also provides a global dim ceiling for the bright tricolour LEDs and an "any active" status bit.

Parameters:
- NUM_LEDS, 8, number of activity channels.
- PWM_BITS, 3, PWM counter width; one PWM period is 2^PWM_BITS clocks.
- DECAY_DIV, 4, clocks per decay tick; must be >= 1.
- DIM_LEVEL, 1, level loaded on activity when dim_en=1; range 0..2^PWM_BITS.

Ports:
- clock  input  1  block clock (slow LED clock domain).
- res_n  input  1  asynchronous active-low reset.
- led_in  input  NUM_LEDS  raw activity bits; asynchronous to clock (core cog domain).
- dim_en  input  1  1 = activity loads DIM_LEVEL; 0 = activity loads full level.
- led_out  output  NUM_LEDS  registered PWM drive, one bit per channel.
- any_active  output  1  registered; 1 when any channel level is non-zero.

Behaviour:
- Reset (res_n=0, asynchronous): clears sync flops, pwm_cnt, decay prescaler, all levels, led_out and any_active to 0. Everything is held at 0 while res_n=0.
- Synchroniser: 2-flop synchroniser per led_in bit (s1 -> s2). Only s2 is used downstream.
- PWM counter: pwm_cnt is PWM_BITS wide. It increments every clock and wraps from 2^PWM_BITS-1 to 0.
- Decay prescaler:
  - Counts 0..DECAY_DIV-1 and wraps to 0.
  - tick=1 for exactly one clock, in the cycle where count == DECAY_DIV-1.
  - With DECAY_DIV=1, tick is high every cycle.
- Per-channel level:
  - Width PWM_BITS+1; range 0..FULL, where FULL = 2^PWM_BITS.
  - If s2[i]=1: level <= (dim_en ? DIM_LEVEL : FULL).
  - Else if tick: level <= level-1, saturating at 0; never wraps.
  - Else: level holds.
- Simultaneous events: activity and tick in the same cycle → the load wins.
- dim_en toggling affects only subsequent loads. Levels already above DIM_LEVEL decay normally.
- Output: led_out[i] <= ({1'b0,pwm_cnt} < level[i]), registered.
  - level=0 → constant 0.
  - level=FULL → constant 1.
  - level=k → high for exactly k of every 2^PWM_BITS clocks, at pwm_cnt values 0..k-1.
- any_active <= OR over channels of (level != 0), registered.
- Latency: led_in rising before clock edge 1 → s1 at edge 1, s2 at edge 2, level at edge 3, led_out at edge 4 (when level=FULL).
- Input pulses: any led_in pulse that s1 samples is captured. Pulses narrower than one clock may be missed; this is accepted.
- Decay time from FULL to 0: FULL × DECAY_DIV clocks at most, after the last cycle with s2=1.
- Reset mid-fade: outputs drop to 0 immediately (asynchronously). After res_n rises, the block restarts from the all-zero state; there is no state carry-over.

Decomposition:
- Shared package led_pkg:
  - function computing FULL from PWM_BITS.
  - typedef for the level type (logic [PWM_BITS:0]).
- One sub-module, led_fader_channel. It holds:
  - the synchroniser
  - the level register with load/decay/saturate
  - the output compare
- Its inputs: pwm_cnt, tick, dim_en.
- Top instantiates NUM_LEDS channels via generate, plus the shared pwm_cnt, prescaler and any_active OR.

Test Plan (defaults: PWM_BITS=3, DECAY_DIV=4, DIM_LEVEL=1; FULL=8):
- Reset: res_n=0 with led_in=8'hFF → led_out=0 and any_active=0 throughout. Release with led_in=0 → both stay 0 for 200 clocks.
- Hold led_in[0]=1 from before edge 1 → led_out[0]=1 from edge 4 onward, continuously. Other bits stay 0. any_active=1 from edge 4.
- One-clock pulse on led_in[2] → level loads 8, then decrements once per tick. Measured duty per 8-clock window is non-increasing 8→0. led_out[2] is constant 0 within 32 clocks after load. any_active falls one clock after the level reaches 0.
- dim_en=1, hold led_in[5]=1 → led_out[5] high exactly when pwm_cnt==0 (1 of every 8 clocks).
- Hold led_in[3]=1 across many tick cycles → level stays 8 (load beats decay) and led_out[3] never drops.
- Assert res_n=0 mid-fade with level=5 → led_out and any_active go 0 before the next clock edge. After release, with no input, they stay 0.
